// File: rtl/glbl_seq.sv
// Staged global reset sequencer: holds every channel in reset, then releases
// them one at a time in ascending order, with an independent timer for the global tristate.
module glbl_seq #(
  parameter int CH        = 3,
  parameter int ROC_CYC   = 100,
  parameter int STAGE_GAP = 4,
  parameter int TOC_CYC   = 0,
  parameter int CNT_W     = 16
) (
  input  logic          mclk,
  input  logic          puc_rst,
  input  logic          hold,
  input  logic          seq_req,
  output logic [CH-1:0] rst_o,
  output logic          gts_o,
  output logic          seq_busy,
  output logic          seq_done
);

  localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;
  localparam int TOC_EFF = (TOC_CYC > 1) ? TOC_CYC : 1;

  // Each counter holds (edges counted so far - 1) when its release edge arrives
  localparam logic [CNT_W-1:0] ROC_LAST = CNT_W'(ROC_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TOC_LAST = CNT_W'(TOC_EFF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH - 1);

  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    STAGE  = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] gcnt;
  logic [IDX_W-1:0] stage_idx;

  always_ff @(posedge mclk) begin
    if (puc_rst || (state == DONE && seq_req)) begin
      state     <= ASSERT;
      cnt       <= '0;
      gcnt      <= '0;
      stage_idx <= '0;
      rst_o     <= '1;
      gts_o     <= 1'b1;
      seq_busy  <= 1'b1;
      seq_done  <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      if (!hold) begin
        if (gts_o) begin
          if (gcnt >= TOC_LAST) gts_o <= 1'b0;
          else                  gcnt  <= gcnt + CNT_W'(1);
        end

        // Channels release as a thermometer: shifting left clears the lowest set bit
        case (state)
          ASSERT: begin
            if (cnt >= ROC_LAST) begin
              cnt   <= '0;
              rst_o <= rst_o << 1;
              if (CH == 1) begin
                state    <= DONE;
                seq_busy <= 1'b0;
                seq_done <= 1'b1;
              end else begin
                state     <= STAGE;
                stage_idx <= IDX_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          STAGE: begin
            if (cnt >= GAP_LAST) begin
              cnt   <= '0;
              rst_o <= rst_o << 1;
              if (stage_idx == IDX_LAST) begin
                state    <= DONE;
                seq_busy <= 1'b0;
                seq_done <= 1'b1;
              end else begin
                stage_idx <= stage_idx + IDX_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DONE: ;
          default: state <= ASSERT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glbl_seq.sv
// Scoreboard bench for glbl_seq: a default instance and a single-channel instance share
// stimulus; expected outputs come from edge-count arithmetic, not from the FSM structure.
module tb_glbl_seq;

  logic       mclk = 1'b0;
  logic       puc_rst = 1'b0;
  logic       hold = 1'b0;
  logic       seq_req = 1'b0;
  logic [2:0] rst_o;
  logic       gts_o, seq_busy, seq_done;
  logic [0:0] s_rst_o;
  logic       s_gts_o, s_busy, s_done;

  always #5 mclk = ~mclk;

  glbl_seq u_dut (
    .mclk(mclk), .puc_rst(puc_rst), .hold(hold), .seq_req(seq_req),
    .rst_o(rst_o), .gts_o(gts_o), .seq_busy(seq_busy), .seq_done(seq_done)
  );

  glbl_seq #(.CH(1), .ROC_CYC(1), .STAGE_GAP(1), .TOC_CYC(5), .CNT_W(8)) u_small (
    .mclk(mclk), .puc_rst(puc_rst), .hold(hold), .seq_req(seq_req),
    .rst_o(s_rst_o), .gts_o(s_gts_o), .seq_busy(s_busy), .seq_done(s_done)
  );

  typedef struct {
    logic [31:0] rst;
    logic        gts;
    logic        busy;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_s[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_main = 0;
  int   n_small = 0;
  bit   model_valid = 0;

  // Edge n after reset/restart: channel k is released once n reaches ROC + k*GAP
  function automatic exp_t modelOut(int n, bit counted, int ch, int roc, int gap, int toc);
    exp_t e;
    int   tend;
    tend   = roc + (ch - 1) * gap;
    e.rst  = '0;
    for (int k = 0; k < ch; k++) e.rst[k] = (n < roc + k * gap);
    e.gts  = (n < ((toc > 1) ? toc : 1));
    e.busy = (n < tend);
    e.done = counted && (n == tend);
    e.cyc  = cyc;
    return e;
  endfunction

  function automatic int modelStep(int n, logic r, logic h, logic q, int tend, output bit counted);
    counted = 1'b0;
    if (r) return 0;
    if (q && n >= tend) return 0;
    if (h) return n;
    counted = 1'b1;
    return (n < 1000000) ? n + 1 : n;
  endfunction

  task automatic applyStimulus(input logic r, input logic h, input logic q);
    bit cm, cs;
    @(negedge mclk);
    puc_rst = r;
    hold    = h;
    seq_req = q;
    cyc++;
    n_main  = modelStep(n_main, r, h, q, 108, cm);
    n_small = modelStep(n_small, r, h, q, 1, cs);
    if (r) model_valid = 1;
    if (model_valid) begin
      exp_q.push_back(modelOut(n_main, cm, 3, 100, 4, 0));
      exp_s.push_back(modelOut(n_small, cs, 1, 1, 1, 5));
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e, input logic [31:0] r,
                             input logic g, input logic b, input logic d);
    total++;
    if (r !== e.rst || g !== e.gts || b !== e.busy || d !== e.done) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got rst=%b gts=%b busy=%b done=%b want rst=%b gts=%b busy=%b done=%b",
               name, e.cyc, r[2:0], g, b, d, e.rst[2:0], e.gts, e.busy, e.done);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge mclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("main", e, {29'd0, rst_o}, gts_o, seq_busy, seq_done);
      end
      if (exp_s.size() > 0) begin
        e = exp_s.pop_front();
        checkOutput("small", e, {31'd0, s_rst_o}, s_gts_o, s_busy, s_done);
      end
    end
  end

  initial begin
    $display("[TB] start");
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    repeat (115) applyStimulus(0, 0, 0);

    applyStimulus(0, 0, 1);
    repeat (112) applyStimulus(0, 0, 0);

    applyStimulus(0, 1, 1);
    repeat (50) applyStimulus(0, 0, 0);
    repeat (10) applyStimulus(0, 1, 0);
    repeat (75) applyStimulus(0, 0, 0);

    applyStimulus(1, 0, 0);
    repeat (101) applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 1);
    repeat (10) applyStimulus(0, 0, 0);

    applyStimulus(1, 1, 1);
    repeat (105) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    repeat (115) applyStimulus(0, 0, 0);

    for (int i = 0; i < 1500; i++)
      applyStimulus($urandom_range(0, 999) < 3, $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 5);
    applyStimulus(0, 0, 0);

    for (int i = 0; i < 5 && (exp_q.size() > 0 || exp_s.size() > 0); i++) @(posedge mclk);
    #2;
    if (exp_q.size() > 0 || exp_s.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain got pending=%0d want pending=0", exp_q.size() + exp_s.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
